// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin arbiter sharing one combinational FP32 multiplier
//
// Purpose:
//   NUM_REQ requesters compete for one shared FP32 multiplier. A round-robin
//   winner's operands are registered onto mul_a/mul_b. The block then waits
//   MUL_LAT cycles, captures mul_result, and presents it with the winner's ID
//   under valid/ready handshaking. Only one operation is in flight at a time.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake (at most one req_ready high)
//   req_a/req_b           packed operands, requester i at [32*i+31:32*i]
//   mul_a/mul_b           registered operands to the shared multiplier
//   mul_result            product returned by the shared multiplier
//   out_valid/out_ready   result handshake
//   out_result/out_id     captured product and owning requester index
//   busy                  high whenever the block is not idle
//   perf_ops/perf_stall   (only with FPMUL_ARB_PERF_EN) saturating counters of
//                         result handshakes and result-stall cycles
//
// Configuration macro: FPMUL_ARB_PERF_EN

module fp_mul_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter int  MUL_LAT = 1,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    output logic [31:0]            mul_a,
    output logic [31:0]            mul_b,
    input  logic [31:0]            mul_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_result,
    output logic [ID_W-1:0]        out_id,
    output logic                   busy
`ifdef FPMUL_ARB_PERF_EN
    ,
    output logic [31:0]            perf_ops,
    output logic [31:0]            perf_stall
`endif
);

    localparam int               CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   rr_last_q, rr_last_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic [31:0]       mul_a_q, mul_a_d;
    logic [31:0]       mul_b_q, mul_b_d;
    logic [31:0]       out_result_q, out_result_d;

    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   cand_idx;
    logic [31:0]       win_a, win_b;
    logic              accept;

    // Round-robin search: start just after the last accepted requester and wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = ID_W'((int'(rr_last_q) + k) % NUM_REQ);
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                win_a = req_a[32*i +: 32];
                win_b = req_b[32*i +: 32];
            end
        end
    end

    // A new operation may start from IDLE, or from DONE in the same cycle the
    // pending result is consumed (back-to-back, no bubble).
    assign accept = win_found &&
                    ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rr_last_q    <= ID_LAST;
            id_q         <= '0;
            out_id_q     <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            out_result_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_last_q    <= rr_last_d;
            id_q         <= id_d;
            out_id_q     <= out_id_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            out_result_q <= out_result_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_last_d    = rr_last_q;
        id_d         = id_q;
        out_id_d     = out_id_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        out_result_d = out_result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    out_result_d = mul_result;
                    out_id_d     = id_q;
                    state_d      = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = accept ? S_WAIT : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // mul_a/mul_b only move on an accept, so the multiplier is never
        // re-driven while a captured result is still waiting.
        if (accept) begin
            mul_a_d   = win_a;
            mul_b_d   = win_b;
            id_d      = win_idx;
            rr_last_d = win_idx;
            cnt_d     = CNT_LOAD;
        end
    end

    // Outputs
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win_idx] = 1'b1;
        end
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign out_result = out_result_q;
    assign out_id     = out_id_q;

`ifdef FPMUL_ARB_PERF_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    // Both counters saturate at all-ones rather than wrapping.
    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if ((state_q == S_DONE) && out_ready && (perf_ops_q != '1)) begin
            perf_ops_d = perf_ops_q + 32'd1;
        end
        if ((state_q == S_DONE) && !out_ready && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb/tb_fp_mul_arbiter.sv - self-checking bench for fp_mul_arbiter (MUL_LAT=1 and MUL_LAT=3 instances)

module tb_fp_mul_arbiter;

    localparam int NR   = 4;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [1:0][3:0]   rv;
    logic [1:0][127:0] ra;
    logic [1:0][127:0] rb;
    logic [1:0]        ordy;

    logic [3:0]  rr0, rr1;
    logic [31:0] ma0, ma1, mb0, mb1, mres0, mres1, ores0, ores1;
    logic        ov0, ov1, bsy0, bsy1;
    logic [1:0]  oid0, oid1;
`ifdef FPMUL_ARB_PERF_EN
    logic [31:0] pops0, pstall0, pops1, pstall1;
`endif

    logic [1:0][3:0]  rr_v;
    logic [1:0][31:0] ma_v, mb_v, ores_v;
    logic [1:0]       ov_v, bsy_v;
    logic [1:0][1:0]  oid_v;
    assign rr_v   = {rr1, rr0};
    assign ma_v   = {ma1, ma0};
    assign mb_v   = {mb1, mb0};
    assign ores_v = {ores1, ores0};
    assign ov_v   = {ov1, ov0};
    assign bsy_v  = {bsy1, bsy0};
    assign oid_v  = {oid1, oid0};

    fp_mul_arbiter #(.NUM_REQ(NR), .MUL_LAT(LAT0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rr0),
        .req_a(ra[0]), .req_b(rb[0]), .mul_a(ma0), .mul_b(mb0), .mul_result(mres0),
        .out_valid(ov0), .out_ready(ordy[0]), .out_result(ores0), .out_id(oid0), .busy(bsy0)
`ifdef FPMUL_ARB_PERF_EN
        , .perf_ops(pops0), .perf_stall(pstall0)
`endif
    );

    fp_mul_arbiter #(.NUM_REQ(NR), .MUL_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rr1),
        .req_a(ra[1]), .req_b(rb[1]), .mul_a(ma1), .mul_b(mb1), .mul_result(mres1),
        .out_valid(ov1), .out_ready(ordy[1]), .out_result(ores1), .out_id(oid1), .busy(bsy1)
`ifdef FPMUL_ARB_PERF_EN
        , .perf_ops(pops1), .perf_stall(pstall1)
`endif
    );

    // Plain FP32 multiply for normal operands (truncating); exact for the directed values.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        int          e;
        logic [22:0] f;
        p = {25'd0, 1'b1, a[22:0]} * {25'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            f = p[46:24];
            e = e + 1;
        end else begin
            f = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], f};
    endfunction

    // Shared-multiplier stand-ins: output is garbage until operands have been
    // stable for the configured latency.
    int          age0 = 100, age1 = 100;
    logic [31:0] pa0 = '0, pb0 = '0, pa1 = '0, pb1 = '0;
    always @(negedge clk) begin
        if (ma0 !== pa0 || mb0 !== pb0) age0 <= 1;
        else if (age0 < 100)            age0 <= age0 + 1;
        if (ma1 !== pa1 || mb1 !== pb1) age1 <= 1;
        else if (age1 < 100)            age1 <= age1 + 1;
        pa0 <= ma0; pb0 <= mb0; pa1 <= ma1; pb1 <= mb1;
    end
    assign mres0 = (age0 >= LAT0) ? fmul(ma0, mb0) : 32'hDEADBEEF;
    assign mres1 = (age1 >= LAT1) ? fmul(ma1, mb1) : 32'hDEADBEEF;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Transaction-level reference model, one per DUT.
    int          have_op[2], rdy_cyc[2], last[2], m_id[2];
    logic [31:0] m_res[2], m_a[2], m_b[2];
    logic [3:0]  acc[2];
    int          lat[2];
    int          cyc;
    int          pm_ops, pm_stall;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            have_op[d] = 0;
            last[d]    = NR - 1;
            acc[d]     = '0;
        end
        pm_ops   = 0;
        pm_stall = 0;
    endtask

    // Called at a negedge with inputs already driven; checks, advances the model, waits one cycle.
    task automatic step();
        bit         ev, allowed;
        int         w;
        logic [3:0] exp_rr;
        #1;
        for (int d = 0; d < 2; d++) begin
            ev = (have_op[d] != 0) && (cyc >= rdy_cyc[d]);
            chk($sformatf("d%0d out_valid", d), 32'(ov_v[d]), 32'(ev));
            chk($sformatf("d%0d busy", d), 32'(bsy_v[d]), 32'(have_op[d] != 0));
            if (ev) begin
                chk($sformatf("d%0d out_result", d), ores_v[d], m_res[d]);
                chk($sformatf("d%0d out_id", d), 32'(oid_v[d]), 32'(m_id[d]));
            end
            if (have_op[d] != 0) begin
                chk($sformatf("d%0d mul_a stable", d), ma_v[d], m_a[d]);
                chk($sformatf("d%0d mul_b stable", d), mb_v[d], m_b[d]);
            end
            allowed = (have_op[d] == 0) || (ev && ordy[d]);
            w = -1;
            if (allowed) begin
                for (int k = 1; k <= NR; k++) begin
                    int i;
                    i = (last[d] + k) % NR;
                    if (w < 0 && rv[d][i]) w = i;
                end
            end
            exp_rr = '0;
            if (w >= 0) exp_rr[w] = 1'b1;
            chk($sformatf("d%0d req_ready", d), 32'(rr_v[d]), 32'(exp_rr));
            if (d == 0 && ev) begin
                if (ordy[0]) pm_ops++;
                else         pm_stall++;
            end
            if (ev && ordy[d]) have_op[d] = 0;
            acc[d] = '0;
            if (w >= 0) begin
                have_op[d] = 1;
                rdy_cyc[d] = cyc + lat[d] + 1;
                m_id[d]    = w;
                m_a[d]     = ra[d][32*w +: 32];
                m_b[d]     = rb[d][32*w +: 32];
                m_res[d]   = fmul(m_a[d], m_b[d]);
                last[d]    = w;
                acc[d][w]  = 1'b1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        rv   = '0;
        ordy = 2'b11;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Waits for a result on the DUTs in mask and compares it with fixed values.
    task automatic wait_res(input bit [1:0] mask, input logic [31:0] er, input int eid, input string nm);
        bit [1:0] seen;
        seen = '0;
        for (int t = 0; t < 12 && seen != mask; t++) begin
            #1;
            for (int d = 0; d < 2; d++) begin
                if (mask[d] && !seen[d] && ov_v[d]) begin
                    seen[d] = 1'b1;
                    chk($sformatf("%s d%0d result", nm, d), ores_v[d], er);
                    chk($sformatf("%s d%0d id", nm, d), 32'(oid_v[d]), 32'(eid));
                end
            end
            step();
        end
        for (int d = 0; d < 2; d++)
            if (mask[d] && !seen[d]) chk($sformatf("%s d%0d timeout", nm, d), 32'd0, 32'd1);
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first[2];
        int seq[$];
        int stalls, accepts;

        lat[0] = LAT0;
        lat[1] = LAT1;
        cyc    = 0;
        rst    = 1'b0;
        rv     = '0;
        ra     = '0;
        rb     = '0;
        ordy   = 2'b11;
        model_reset();

        // Reset values
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst d%0d out_valid", d), 32'(ov_v[d]), 32'd0);
            chk($sformatf("rst d%0d busy", d), 32'(bsy_v[d]), 32'd0);
            chk($sformatf("rst d%0d mul_a", d), ma_v[d], 32'd0);
            chk($sformatf("rst d%0d mul_b", d), mb_v[d], 32'd0);
            chk($sformatf("rst d%0d out_result", d), ores_v[d], 32'd0);
            chk($sformatf("rst d%0d out_id", d), 32'(oid_v[d]), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single-operation vectors, applied to both instances
        tbl[0] = '{0, 32'h40400000, 32'h40000000, 32'h40C00000};
        tbl[1] = '{2, 32'h3FC00000, 32'h3FC00000, 32'h40100000};
        tbl[2] = '{1, 32'hC0000000, 32'h40800000, 32'hC1000000};
        tbl[3] = '{3, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        tbl[4] = '{0, 32'h40000000, 32'hC0400000, 32'hC0C00000};
        for (int v = 0; v < 5; v++) begin
            for (int d = 0; d < 2; d++) begin
                rv[d] = '0;
                rv[d][tbl[v].id] = 1'b1;
                ra[d][32*tbl[v].id +: 32] = tbl[v].a;
                rb[d][32*tbl[v].id +: 32] = tbl[v].b;
                first[d] = -1;
            end
            ordy = 2'b11;
            #1;
            for (int d = 0; d < 2; d++)
                chk($sformatf("vec%0d d%0d req_ready", v, d), 32'(rr_v[d]), 32'd1 << tbl[v].id);
            step();
            rv = '0;
            for (int t = 1; t <= 8; t++) begin
                #1;
                for (int d = 0; d < 2; d++) begin
                    if (ov_v[d] && first[d] < 0) begin
                        first[d] = t;
                        chk($sformatf("vec%0d d%0d result", v, d), ores_v[d], tbl[v].res);
                        chk($sformatf("vec%0d d%0d id", v, d), 32'(oid_v[d]), 32'(tbl[v].id));
                    end
                end
                step();
            end
            for (int d = 0; d < 2; d++)
                chk($sformatf("vec%0d d%0d latency", v, d), 32'(first[d]), 32'(lat[d] + 1));
        end

        // Round-robin with all requesters valid
        do_reset();
        for (int i = 0; i < NR; i++) begin
            ra[0][32*i +: 32] = 32'h3F800000 + (32'(i) << 20);
            rb[0][32*i +: 32] = 32'h40000000;
        end
        rv[0] = 4'hF;
        for (int t = 0; t < 30 && seq.size() < 5; t++) begin
            #1;
            if (rr_v[0] != 0) begin
                chk("rr onehot", 32'($countones(rr_v[0])), 32'd1);
                for (int i = 0; i < NR; i++) if (rr_v[0][i]) seq.push_back(i);
            end
            step();
        end
        chk("rr grant count", 32'(seq.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("rr grant %0d", k), (k < seq.size()) ? 32'(seq[k]) : 32'hFFFFFFFF, 32'(k % NR));
        rv = '0;
        for (int t = 0; t < 4; t++) step();

        // Backpressure, then back-to-back accept of requester 2
        rv[0] = 4'b0001;
        ra[0][31:0] = 32'h40400000;
        rb[0][31:0] = 32'h40000000;
        step();
        rv[0] = '0;
        step();
        ordy[0] = 1'b0;
        rv[0]   = 4'b0100;
        ra[0][95:64] = 32'h3FC00000;
        rb[0][95:64] = 32'h3FC00000;
        for (int t = 0; t < 5; t++) begin
            #1;
            chk("bp out_valid", 32'(ov_v[0]), 32'd1);
            chk("bp out_result", ores_v[0], 32'h40C00000);
            chk("bp no req_ready", 32'(rr_v[0]), 32'd0);
            step();
        end
        ordy[0] = 1'b1;
        #1;
        chk("b2b req_ready", 32'(rr_v[0]), 32'b0100);
        step();
        rv[0] = '0;
        wait_res(2'b01, 32'h40100000, 2, "b2b");

        // Reset while an operation is in WAIT
        for (int d = 0; d < 2; d++) begin
            rv[d] = 4'b0010;
            ra[d][63:32] = 32'hC0000000;
            rb[d][63:32] = 32'h40800000;
        end
        step();
        rv = '0;
        step();
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("midrst d%0d out_valid", d), 32'(ov_v[d]), 32'd0);
            chk($sformatf("midrst d%0d busy", d), 32'(bsy_v[d]), 32'd0);
            chk($sformatf("midrst d%0d mul_a", d), ma_v[d], 32'd0);
            chk($sformatf("midrst d%0d mul_b", d), mb_v[d], 32'd0);
            chk($sformatf("midrst d%0d out_result", d), ores_v[d], 32'd0);
            chk($sformatf("midrst d%0d out_id", d), 32'(oid_v[d]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            rv[d] = 4'b1000;
            ra[d][127:96] = 32'h3F800000;
            rb[d][127:96] = 32'h40000000;
        end
        #1;
        for (int d = 0; d < 2; d++)
            chk($sformatf("postrst d%0d req_ready", d), 32'(rr_v[d]), 32'b1000);
        step();
        rv = '0;
        wait_res(2'b11, 32'h40000000, 3, "postrst");

        // Randomized traffic checked against the model
        for (int t = 0; t < 800; t++) begin
            for (int d = 0; d < 2; d++) begin
                ordy[d] = ($urandom_range(9) < 7);
                for (int i = 0; i < NR; i++) begin
                    if (acc[d][i]) rv[d][i] = 1'b0;
                    if (!rv[d][i] && $urandom_range(2) == 0) begin
                        rv[d][i] = 1'b1;
                        ra[d][32*i +: 32] = $urandom;
                        rb[d][32*i +: 32] = $urandom;
                    end
                end
            end
            step();
        end
        rv   = '0;
        ordy = 2'b11;
        for (int t = 0; t < 10; t++) step();

`ifdef FPMUL_ARB_PERF_EN
        // Three completed operations with two stall cycles
        do_reset();
        stalls  = 2;
        accepts = 0;
        rv[0]   = 4'b0001;
        ra[0][31:0] = 32'h40400000;
        rb[0][31:0] = 32'h40000000;
        for (int t = 0; t < 40 && pm_ops < 3; t++) begin
            if (acc[0][0]) begin
                accepts++;
                if (accepts >= 3) rv[0][0] = 1'b0;
            end
            ordy[0] = !(ov0 && stalls > 0);
            if (ov0 && stalls > 0) stalls--;
            step();
        end
        ordy[0] = 1'b1;
        #1;
        chk("perf_ops", pops0, 32'd3);
        chk("perf_stall", pstall0, 32'd2);
`else
        stalls  = 0;
        accepts = stalls;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
